// File: rtl/sop_eval_pkg.sv
// Shared types and reset constants for the sequential sum-of-products evaluator.
package sop_eval_pkg;

    localparam int SOP_N_IN = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // One product term at the default input width
    typedef struct packed {
        logic                act;
        logic [SOP_N_IN-1:0] care;
        logic [SOP_N_IN-1:0] val;
    } sop_term_t;

    localparam sop_term_t SOP_TERM_RST = '0;
    localparam logic      SOP_Y_RST    = 1'b0;

endpackage

// File: rtl/sop_term_match.sv
// Single product-term comparator: a term matches when it is active and every cared-for literal agrees.
module sop_term_match #(
    parameter int N_IN = 4
) (
    input  logic [N_IN-1:0] vec_i,
    input  logic [N_IN-1:0] care_i,
    input  logic [N_IN-1:0] val_i,
    input  logic            act_i,
    output logic            match_o
);

    assign match_o = act_i && (((vec_i ^ val_i) & care_i) == '0);

endmodule

// File: rtl/sop_eval_seq.sv
// Programmable SOP evaluator: loadable term table scanned one term per cycle by a small FSM.
// Define SOP_EARLY_EXIT_EN to finish the scan at the first matching term.
module sop_eval_seq
    import sop_eval_pkg::*;
#(
    parameter int N_IN      = SOP_N_IN,
    parameter int NUM_TERMS = 8,
    parameter int IDX_W     = $clog2(NUM_TERMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_act,
    input  logic [N_IN-1:0]  wr_care,
    input  logic [N_IN-1:0]  wr_val,
    input  logic             start,
    input  logic [N_IN-1:0]  in_vec,
    output logic             busy,
    output logic             done,
    output logic             y,
    output logic [IDX_W-1:0] hit_idx
);

    typedef struct packed {
        logic            act;
        logic [N_IN-1:0] care;
        logic [N_IN-1:0] val;
    } term_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TERMS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] hit_q, hit_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic             y_q, y_d;
    term_t            table_q [NUM_TERMS];
    term_t            cur_term;
    logic             match;
    logic             wr_ok;

    // The table is frozen while a scan is running so results never mix two table versions
    assign wr_ok = wr_en && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TERMS; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_ok) begin
            for (int i = 0; i < NUM_TERMS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    table_q[i] <= '{act: wr_act, care: wr_care, val: wr_val};
                end
            end
        end
    end

    assign cur_term = table_q[idx_q];

    sop_term_match #(
        .N_IN(N_IN)
    ) u_match (
        .vec_i  (vec_q),
        .care_i (cur_term.care),
        .val_i  (cur_term.val),
        .act_i  (cur_term.act),
        .match_o(match)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hit_q   <= '0;
            vec_q   <= '0;
            y_q     <= SOP_Y_RST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            vec_q   <= vec_d;
            y_q     <= y_d;
        end
    end

    // y_q doubles as the "already hit" flag so only the lowest matching index is kept
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        vec_d   = vec_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    vec_d   = in_vec;
                    y_d     = 1'b0;
                    hit_d   = '0;
                end
            end
            SCAN: begin
                if (match && !y_q) begin
                    y_d   = 1'b1;
                    hit_d = idx_q;
                end
`ifdef SOP_EARLY_EXIT_EN
                if (match || (idx_q == LAST_IDX)) begin
`else
                if (idx_q == LAST_IDX) begin
`endif
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign y       = y_q;
    assign hit_idx = hit_q;

endmodule
